// File: rtl/clk_transmitter_if.sv
// Signal bundle for clk_transmitter: cycle qualifier, run control, rate and
// data handshakes, and the registered pin/strobe outputs.
interface clk_transmitter_if #(
    parameter int RATE_COUNTER_WIDTH = 16
);
    logic                          clk_en;
    logic                          generation_en_i;
    logic                          starting_polarity_i;
    logic                          rate_valid_i;
    logic                          rate_ready_o;
    logic [RATE_COUNTER_WIDTH-1:0] high_rate_i;
    logic [RATE_COUNTER_WIDTH-1:0] low_rate_i;
    logic                          tx_valid_i;
    logic                          tx_ready_o;
    logic                          tx_data_i;
    logic                          clk_o;
    logic                          clk_n_o;
    logic                          data_o;
    logic                          rising_o;
    logic                          falling_o;
    logic                          underrun_o;
    logic                          rate_changed_o;
    logic [RATE_COUNTER_WIDTH-1:0] active_high_rate_o;
    logic [RATE_COUNTER_WIDTH-1:0] active_low_rate_o;

    // Stimulus / controlling side
    modport master (
        output clk_en, generation_en_i, starting_polarity_i,
        output rate_valid_i, high_rate_i, low_rate_i,
        output tx_valid_i, tx_data_i,
        input  rate_ready_o, tx_ready_o,
        input  clk_o, clk_n_o, data_o,
        input  rising_o, falling_o, underrun_o, rate_changed_o,
        input  active_high_rate_o, active_low_rate_o
    );

    // Transmitter side
    modport slave (
        input  clk_en, generation_en_i, starting_polarity_i,
        input  rate_valid_i, high_rate_i, low_rate_i,
        input  tx_valid_i, tx_data_i,
        output rate_ready_o, tx_ready_o,
        output clk_o, clk_n_o, data_o,
        output rising_o, falling_o, underrun_o, rate_changed_o,
        output active_high_rate_o, active_low_rate_o
    );
endinterface

// File: rtl/clk_transmitter.sv
// Programmable I/O clock generator with a 1-bit serializer. Data launches on
// the clk_o falling edge so the far end can sample on the rising edge. Phase
// lengths are counted in enabled system cycles; new rates are staged in a
// one-entry pending register and only take effect at a period boundary.
module clk_transmitter #(
    parameter int RATE_COUNTER_WIDTH = 16,
    parameter int DEFAULT_HIGH_RATE  = 4,
    parameter int DEFAULT_LOW_RATE   = 4
) (
    input logic              clk,
    input logic              async_rst,
    clk_transmitter_if.slave bus
);
    localparam int W = RATE_COUNTER_WIDTH;
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] DEF_HIGH = W'(DEFAULT_HIGH_RATE);
    localparam logic [W-1:0] DEF_LOW  = W'(DEFAULT_LOW_RATE);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t         r_state, w_state_next;
    logic [W-1:0]   r_count, w_count_next;
    logic [W-1:0]   r_act_high, w_act_high_next;
    logic [W-1:0]   r_act_low, w_act_low_next;
    logic [W-1:0]   r_pend_high, w_pend_high_next;
    logic [W-1:0]   r_pend_low, w_pend_low_next;
    // rate_ready is the inverse of "pending register full"
    logic           r_rate_ready, w_rate_ready_next;
    logic           r_clk, w_clk_next;
    logic           r_clk_n, w_clk_n_next;
    logic           r_data, w_data_next;
    logic           r_rising, w_rising_next;
    logic           r_falling, w_falling_next;
    logic           r_underrun, w_underrun_next;
    logic           r_rate_changed, w_rate_changed_next;
    logic           r_tx_ready, w_tx_ready_next;

    logic           w_start;
    logic           w_low_expire_run;
    logic           w_commit;
    logic [W-1:0]   w_use_high;
    logic [W-1:0]   w_use_low;

    function automatic logic [W-1:0] clamp_rate(input logic [W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // Pending rates are committed when a new period begins: start from IDLE
    // or LOW expiry while still running. The committed values must be used
    // for the phase that starts in the same cycle.
    assign w_start          = (r_state == S_IDLE) && bus.generation_en_i;
    assign w_low_expire_run = (r_state == S_LOW) && (r_count == '0) && bus.generation_en_i;
    assign w_commit         = (w_start || w_low_expire_run) && !r_rate_ready;
    assign w_use_high       = w_commit ? r_pend_high : r_act_high;
    assign w_use_low        = w_commit ? r_pend_low : r_act_low;

    // Next-state, phase counter, rate staging and launch decisions
    always_comb begin
        w_state_next        = r_state;
        w_count_next        = r_count;
        w_act_high_next     = r_act_high;
        w_act_low_next      = r_act_low;
        w_pend_high_next    = r_pend_high;
        w_pend_low_next     = r_pend_low;
        w_rate_ready_next   = r_rate_ready;
        w_clk_next          = r_clk;
        w_data_next         = r_data;
        w_rising_next       = 1'b0;
        w_falling_next      = 1'b0;
        w_underrun_next     = 1'b0;
        w_rate_changed_next = 1'b0;
        w_tx_ready_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.generation_en_i) begin
                    if (bus.starting_polarity_i) begin
                        w_state_next  = S_HIGH;
                        w_clk_next    = 1'b1;
                        w_rising_next = 1'b1;
                        w_count_next  = w_use_high - ONE;
                    end else begin
                        w_state_next  = S_LOW;
                        w_count_next  = w_use_low - ONE;
                    end
                end
            end
            S_HIGH: begin
                if (r_count == '0) begin
                    // Falling edge: always completes, launches the next bit
                    w_clk_next     = 1'b0;
                    w_falling_next = 1'b1;
                    if (bus.tx_valid_i) begin
                        w_data_next     = bus.tx_data_i;
                        w_tx_ready_next = 1'b1;
                    end else begin
                        w_underrun_next = 1'b1;
                    end
                    if (bus.generation_en_i) begin
                        w_state_next = S_LOW;
                        w_count_next = r_act_low - ONE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_count_next = r_count - ONE;
                end
            end
            S_LOW: begin
                if (r_count == '0) begin
                    if (bus.generation_en_i) begin
                        w_state_next  = S_HIGH;
                        w_clk_next    = 1'b1;
                        w_rising_next = 1'b1;
                        w_count_next  = w_use_high - ONE;
                    end else begin
                        w_state_next  = S_IDLE;
                    end
                end else begin
                    w_count_next = r_count - ONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Commit and capture are exclusive: commit needs a full slot,
        // capture needs an empty one, so a fresh capture is never applied
        // in the cycle it arrives.
        if (w_commit) begin
            w_act_high_next     = r_pend_high;
            w_act_low_next      = r_pend_low;
            w_rate_changed_next = 1'b1;
            w_rate_ready_next   = 1'b1;
        end
        if (bus.rate_valid_i && r_rate_ready) begin
            w_pend_high_next  = clamp_rate(bus.high_rate_i);
            w_pend_low_next   = clamp_rate(bus.low_rate_i);
            w_rate_ready_next = 1'b0;
        end

        w_clk_n_next = ~w_clk_next;
    end

    // State register: everything freezes while clk_en is low
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_act_high     <= DEF_HIGH;
            r_act_low      <= DEF_LOW;
            r_pend_high    <= '0;
            r_pend_low     <= '0;
            r_rate_ready   <= 1'b1;
            r_clk          <= 1'b0;
            r_clk_n        <= 1'b1;
            r_data         <= 1'b0;
            r_rising       <= 1'b0;
            r_falling      <= 1'b0;
            r_underrun     <= 1'b0;
            r_rate_changed <= 1'b0;
            r_tx_ready     <= 1'b0;
        end else if (bus.clk_en) begin
            r_state        <= w_state_next;
            r_count        <= w_count_next;
            r_act_high     <= w_act_high_next;
            r_act_low      <= w_act_low_next;
            r_pend_high    <= w_pend_high_next;
            r_pend_low     <= w_pend_low_next;
            r_rate_ready   <= w_rate_ready_next;
            r_clk          <= w_clk_next;
            r_clk_n        <= w_clk_n_next;
            r_data         <= w_data_next;
            r_rising       <= w_rising_next;
            r_falling      <= w_falling_next;
            r_underrun     <= w_underrun_next;
            r_rate_changed <= w_rate_changed_next;
            r_tx_ready     <= w_tx_ready_next;
        end
    end

    // Strobe registers hold across clk_en gaps; masking with clk_en makes each
    // strobe appear for exactly one enabled cycle and never in a gapped one.
    assign bus.rising_o           = r_rising & bus.clk_en;
    assign bus.falling_o          = r_falling & bus.clk_en;
    assign bus.underrun_o         = r_underrun & bus.clk_en;
    assign bus.rate_changed_o     = r_rate_changed & bus.clk_en;
    assign bus.tx_ready_o         = r_tx_ready & bus.clk_en;
    assign bus.rate_ready_o       = r_rate_ready;
    assign bus.clk_o              = r_clk;
    assign bus.clk_n_o            = r_clk_n;
    assign bus.data_o             = r_data;
    assign bus.active_high_rate_o = r_act_high;
    assign bus.active_low_rate_o  = r_act_low;
endmodule

// File: tb/tb_clk_transmitter.sv
// Scoreboard bench for clk_transmitter. The reference model schedules each
// phase as an absolute enabled-cycle end time and stages rates in a queue;
// strobe events go into a scoreboard that a negedge monitor drains.
module tb_clk_transmitter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic async_rst;
    always #5 clk = ~clk;

    clk_transmitter_if #(.RATE_COUNTER_WIDTH(W)) bus ();

    clk_transmitter #(
        .RATE_COUNTER_WIDTH(W),
        .DEFAULT_HIGH_RATE (4),
        .DEFAULT_LOW_RATE  (4)
    ) dut (
        .clk      (clk),
        .async_rst(async_rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int cur_edge = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cur_edge);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           stamp;
        logic [4:0]   strobes;   // rising, falling, underrun, rate_changed, tx_ready
        logic         clk_lvl;
        logic         data;
        logic [W-1:0] ah;
        logic [W-1:0] al;
    } ev_t;

    ev_t          sb[$];
    bit           m_running, m_level, m_data;
    int           m_en_n, m_phase_end;
    logic [W-1:0] m_act_h, m_act_l;
    logic [W-1:0] m_pq_h[$];
    logic [W-1:0] m_pq_l[$];
    bit           tx_acc, rate_acc;

    function automatic logic [W-1:0] clamp1(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    task automatic model_reset();
        m_running = 0; m_level = 0; m_data = 0;
        m_en_n = 0; m_phase_end = 0;
        m_act_h = W'(4); m_act_l = W'(4);
        m_pq_h.delete(); m_pq_l.delete();
        sb.delete();
    endtask

    task automatic model_step(input bit en, gen, pol, rv, input logic [W-1:0] hr, lr,
                              input bit txv, txd);
        bit rise, fall, und, chg, acc, slot_free;
        ev_t e;
        cur_edge++;
        tx_acc = 0; rate_acc = 0;
        if (!en) return;
        m_en_n++;
        rise = 0; fall = 0; und = 0; chg = 0; acc = 0;
        slot_free = (m_pq_h.size() == 0);
        if (!m_running) begin
            if (gen) begin
                if (!slot_free) begin
                    m_act_h = m_pq_h.pop_front(); m_act_l = m_pq_l.pop_front(); chg = 1;
                end
                m_running = 1;
                m_level = pol;
                rise = pol;
                m_phase_end = m_en_n + int'(pol ? m_act_h : m_act_l);
            end
        end else if (m_en_n == m_phase_end) begin
            if (m_level) begin
                fall = 1; m_level = 0;
                if (txv) begin m_data = txd; acc = 1; tx_acc = 1; end
                else und = 1;
                if (gen) m_phase_end = m_en_n + int'(m_act_l);
                else m_running = 0;
            end else if (gen) begin
                if (!slot_free) begin
                    m_act_h = m_pq_h.pop_front(); m_act_l = m_pq_l.pop_front(); chg = 1;
                end
                m_level = 1; rise = 1;
                m_phase_end = m_en_n + int'(m_act_h);
            end else begin
                m_running = 0;
            end
        end
        if (rv && slot_free) begin
            m_pq_h.push_back(clamp1(hr)); m_pq_l.push_back(clamp1(lr)); rate_acc = 1;
        end
        if (rise || fall || und || chg || acc) begin
            e.stamp = cur_edge; e.strobes = {rise, fall, und, chg, acc};
            e.clk_lvl = m_level; e.data = m_data; e.ah = m_act_h; e.al = m_act_l;
            sb.push_back(e);
        end
    endtask

    // ---------------- stimulus ----------------
    bit           src_rv = 0;
    logic [W-1:0] src_h = '0, src_l = '0;
    bit           tx_q[$];
    bit           tx_refill = 0;

    task automatic cycle(input bit en, gen, pol, rv, input logic [W-1:0] hr, lr,
                         input bit txv, txd);
        bus.clk_en = en; bus.generation_en_i = gen; bus.starting_polarity_i = pol;
        bus.rate_valid_i = rv; bus.high_rate_i = hr; bus.low_rate_i = lr;
        bus.tx_valid_i = txv; bus.tx_data_i = txd;
        @(posedge clk);
        model_step(en, gen, pol, rv, hr, lr, txv, txd);
        #1;
    endtask

    // en_pct < 0 selects a strict 1,0,1,0 clk_en pattern; mode 2 = random
    task automatic run(input int n, input int en_pct, input int gen_mode, input int pol_mode,
                       input int rate_pct, input int tx_pct);
        for (int i = 0; i < n; i++) begin
            bit en, g, p, txv, txd;
            en = (en_pct < 0) ? bit'(i % 2 == 0) : ($urandom_range(99) < en_pct);
            g  = (gen_mode == 2) ? ($urandom_range(99) < 95) : (gen_mode == 1);
            p  = (pol_mode == 2) ? bit'($urandom_range(1)) : (pol_mode == 1);
            if (!src_rv && ($urandom_range(99) < rate_pct)) begin
                src_rv = 1; src_h = W'($urandom_range(5)); src_l = W'($urandom_range(5));
            end
            if (tx_refill && tx_q.size() == 0) tx_q.push_back(bit'($urandom_range(1)));
            txv = (tx_q.size() > 0) && ($urandom_range(99) < tx_pct);
            txd = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
            cycle(en, g, p, src_rv, src_h, src_l, txv, txd);
            if (rate_acc) src_rv = 0;
            if (tx_acc) void'(tx_q.pop_front());
        end
    endtask

    // ---------------- monitor ----------------
    bit         mon_en = 0;
    bit         prev_en = 0;
    int         last_en_edge = 0;
    logic [4:0] mon_s;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_en) last_en_edge = cur_edge;
            prev_en = bus.clk_en;
            chk("clk_o", 32'(bus.clk_o), 32'(m_level));
            chk("clk_n_o", 32'(bus.clk_n_o), 32'(!m_level));
            chk("data_o", 32'(bus.data_o), 32'(m_data));
            chk("rate_ready_o", 32'(bus.rate_ready_o), 32'(m_pq_h.size() == 0));
            chk("active_high", 32'(bus.active_high_rate_o), 32'(m_act_h));
            chk("active_low", 32'(bus.active_low_rate_o), 32'(m_act_l));
            mon_s = {bus.rising_o, bus.falling_o, bus.underrun_o, bus.rate_changed_o, bus.tx_ready_o};
            if (mon_s != 5'b0) begin
                if (!bus.clk_en) chk("strobe_while_gated", 32'(mon_s), 32'(0));
                else if (sb.size() == 0) chk("unexpected_strobe", 32'(mon_s), 32'(0));
                else begin
                    mon_e = sb.pop_front();
                    chk("event_edge", 32'(last_en_edge), 32'(mon_e.stamp));
                    chk("event_strobes", 32'(mon_s), 32'(mon_e.strobes));
                    chk("event_clk", 32'(bus.clk_o), 32'(mon_e.clk_lvl));
                    chk("event_data", 32'(bus.data_o), 32'(mon_e.data));
                    chk("event_high", 32'(bus.active_high_rate_o), 32'(mon_e.ah));
                    chk("event_low", 32'(bus.active_low_rate_o), 32'(mon_e.al));
                end
            end
        end
    end

    task automatic drive_idle();
        bus.clk_en = 1'b1; bus.generation_en_i = 1'b0; bus.starting_polarity_i = 1'b0;
        bus.rate_valid_i = 1'b0; bus.high_rate_i = '0; bus.low_rate_i = '0;
        bus.tx_valid_i = 1'b0; bus.tx_data_i = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_clk_o"}, 32'(bus.clk_o), 32'(0));
        chk({tag, "_clk_n_o"}, 32'(bus.clk_n_o), 32'(1));
        chk({tag, "_data_o"}, 32'(bus.data_o), 32'(0));
        chk({tag, "_rate_ready"}, 32'(bus.rate_ready_o), 32'(1));
        chk({tag, "_act_high"}, 32'(bus.active_high_rate_o), 32'(4));
        chk({tag, "_act_low"}, 32'(bus.active_low_rate_o), 32'(4));
        chk({tag, "_strobes"},
            32'({bus.rising_o, bus.falling_o, bus.underrun_o, bus.rate_changed_o, bus.tx_ready_o}),
            32'(0));
    endtask

    initial begin
        int guard;
        async_rst = 1'b1;
        drive_idle();
        model_reset();
        #12;
        chk_reset_values("reset");
        @(posedge clk); #1;
        async_rst = 1'b0;
        prev_en = 0; mon_en = 1;

        // Default 4/4 run, serial stream 1,0,1,1 then underruns; 3/2 offered mid-HIGH
        tx_q = '{1, 0, 1, 1};
        tx_refill = 0;
        run(2, 100, 1, 1, 0, 100);
        src_rv = 1; src_h = W'(3); src_l = W'(2);
        run(40, 100, 1, 1, 0, 100);

        // Stop to IDLE, stage 4/4, start HIGH, drop run request one cycle in
        run(12, 100, 0, 0, 0, 100);
        src_rv = 1; src_h = W'(4); src_l = W'(4);
        run(2, 100, 0, 0, 0, 100);
        tx_q = '{0, 1};
        run(2, 100, 1, 1, 0, 100);
        run(10, 100, 0, 0, 0, 100);
        run(14, 100, 1, 0, 0, 100);

        // 2/2 with clk_en toggling every cycle, then 0/0 clamped to 1/1
        tx_refill = 1;
        src_rv = 1; src_h = W'(2); src_l = W'(2);
        run(48, -1, 1, 1, 0, 100);
        src_rv = 1; src_h = W'(0); src_l = W'(0);
        run(24, 100, 1, 1, 0, 100);

        // Randomised traffic
        run(1500, 75, 2, 2, 5, 80);

        // Reach a HIGH phase with a rate pending, then reset between clock edges
        guard = 0;
        do begin
            if (!src_rv) begin src_rv = 1; src_h = W'(5); src_l = W'(5); end
            run(1, 100, 1, 1, 0, 100);
            guard++;
        end while (!(m_level && m_pq_h.size() != 0) && guard < 60);
        chk("reach_mid_high", 32'(m_level && m_pq_h.size() != 0), 32'(1));
        #1;
        chk("pre_reset_clk_o", 32'(bus.clk_o), 32'(1));
        mon_en = 0;
        #2;
        async_rst = 1'b1;
        #1;
        chk_reset_values("async");
        model_reset();
        tx_q.delete(); src_rv = 0;
        drive_idle();
        @(posedge clk); #1;
        async_rst = 1'b0;
        prev_en = 0; mon_en = 1;

        // Resume after reset, then drain to IDLE
        run(60, 90, 1, 2, 5, 80);
        tx_refill = 0;
        run(40, 100, 0, 0, 0, 100);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
